// File: rtl/bus_arbiter4_pkg.sv
// Shared constants for the 4-way round-robin bus arbiter.
// State encoding, bus widths and the default hold limit.
package bus_arbiter4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int REQ_W        = 4;
  localparam int SEL_W        = 2;
  localparam int MAX_HOLD_DEF = 8;
  localparam int HC_W         = 8;

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin picker: scans last+1, last+2, last+3, last (mod 4)
// and returns the first set request as valid/index/one-hot.
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             vld,
  output logic [SEL_W-1:0] idx,
  output logic [REQ_W-1:0] onehot
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    vld    = 1'b0;
    idx    = last;
    onehot = '0;
    cand   = last;
    for (int k = 1; k <= REQ_W; k++) begin
      cand = last + SEL_W'(k);
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
    if (vld) begin
      onehot = REQ_W'(1) << idx;
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin owner/select sequencer for the shared 16-bit bus; grants are
// registered one edge after arbitration. Optional ARB_PRIO0_EN gives requester 0 priority.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REQ_W-1:0] REQ,
  input  logic [REQ_W-1:0] DONE,
  output logic [REQ_W-1:0] GNT,
  output logic [SEL_W-1:0] S,
  output logic             BUSY,
  output logic             TIMEOUT
);

  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [REQ_W-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [HC_W-1:0]  hc_q, hc_d;

  logic [REQ_W-1:0] owner_oh;
  logic             rel_done, rel_drop, rel_to, rel_any;
  logic [REQ_W-1:0] arb_req, pick_req;
  logic [SEL_W-1:0] arb_last;
  logic             pick_vld, win_vld;
  logic [SEL_W-1:0] pick_idx, win_idx;
  logic [REQ_W-1:0] pick_oh, win_oh;

  // Arbitration inputs: from IDLE use the stored pointer; on release the owner
  // becomes LAST and is masked only for a voluntary (DONE / REQ-drop) release.
  always_comb begin
    owner_oh = REQ_W'(1) << s_q;
    rel_done = DONE[s_q];
    rel_drop = !REQ[s_q];
    rel_to   = (hc_q == HC_MAX);
    rel_any  = (state_q == ST_GRANT) && (rel_done || rel_drop || rel_to);
    arb_req  = REQ;
    arb_last = last_q;
    if (state_q == ST_GRANT) begin
      arb_last = s_q;
      if (rel_done || rel_drop) begin
        arb_req = REQ & ~owner_oh;
      end
    end
  end

  rr_pick4 u_pick (
    .req    (pick_req),
    .last   (arb_last),
    .vld    (pick_vld),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
`ifdef ARB_PRIO0_EN
    pick_req = {arb_req[REQ_W-1:1], 1'b0};
    if (arb_req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
      win_oh  = REQ_W'(1);
    end else begin
      win_vld = pick_vld;
      win_idx = pick_idx;
      win_oh  = pick_oh;
    end
`else
    pick_req = arb_req;
    win_vld  = pick_vld;
    win_idx  = pick_idx;
    win_oh   = pick_oh;
`endif
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    s_d       = s_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    hc_d      = hc_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          s_d     = win_idx;
          busy_d  = 1'b1;
          hc_d    = '0;
        end
      end
      ST_GRANT: begin
        if (rel_any) begin
          last_d    = s_q;
          // A DONE or REQ-drop in the same cycle takes precedence over the hold limit.
          timeout_d = rel_to && !rel_done && !rel_drop;
          hc_d      = '0;
          if (win_vld) begin
            gnt_d = win_oh;
            s_d   = win_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (hc_q != HC_MAX) begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      s_q       <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= SEL_W'(REQ_W - 1);
      hc_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      hc_q      <= hc_d;
    end
  end

  assign GNT     = gnt_q;
  assign S       = s_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: doc/bus_arbiter4.md
Name: bus_arbiter4

Overview:
Round-robin arbiter and sequencer for the shared 16-bit datapath bus built from the 4:1 data mux.
- Owns the mux select S and issues a one-hot grant to four requesters (register-file read port, ALU, memory interface, immediate unit).
- Each grant is held until the owner signals DONE, drops REQ, or exceeds a hold limit.
- Ownership then rotates fairly.

Parameters:
N_REQ, 4, number of requesters (fixed at 4; S width is 2).
MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced rotation (legal range 2..255).

Ports:
CLK  input  1  system clock, all state on rising edge.
RST  input  1  synchronous active-high reset.
REQ  input  4  request per requester, level-sensitive; bit i = requester i.
DONE  input  4  one-cycle release pulse per requester; only the current owner's bit is honoured.
GNT  output  4  one-hot grant, registered; all zero when bus is idle.
S  output  2  mux select = binary index of current owner, registered.
BUSY  output  1  high while any grant is active (equals OR of GNT).
TIMEOUT  output  1  one-cycle pulse, registered; high in the cycle after a grant is revoked by the hold limit.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. No asynchronous logic.
- Reset values: GNT=0000, S=00, BUSY=0, TIMEOUT=0, state=IDLE, last-owner pointer LAST=3, hold counter HC=0.
- FSM states: IDLE, GRANT.
- IDLE with REQ==0: remain; outputs unchanged. S keeps its last value; do not care when BUSY=0.
- IDLE with REQ!=0:
  - Winner = first set REQ bit scanning LAST+1, LAST+2, LAST+3, LAST (mod 4).
  - Next edge: GNT=onehot(winner), S=winner, BUSY=1, HC=0, state=GRANT.
  - Latency: REQ sampled at edge k gives GNT at edge k+1.
- GRANT: HC increments each cycle, saturating at MAX_HOLD-1.
- Release condition, evaluated each cycle for owner o, any of:
  - DONE[o]=1;
  - REQ[o]=0;
  - HC==MAX_HOLD-1 (timeout).
- On release:
  - LAST=o.
  - Re-arbitrate the same cycle over REQ with REQ[o] masked if DONE or REQ-drop caused the release. On timeout, o is not masked and is simply last in rotation.
  - Winner exists: next edge GNT/S switch directly to the new owner (no idle bubble), HC=0.
  - No winner: next edge GNT=0000, BUSY=0, state=IDLE.
- Timeout with no other requester pending: owner is re-granted, HC=0, TIMEOUT still pulses.
- DONE and REQ changes on non-owner bits are ignored during GRANT. Simultaneous DONE[o] and timeout count as a DONE release (TIMEOUT=0).
- S changes only on grant edges; never glitches mid-grant.
- GNT is always one-hot or zero.
- RST asserted mid-grant: next edge forces reset values regardless of REQ/DONE.

Optional Feature:
ARB_PRIO0_EN
- Defined: requester 0 wins every arbitration point when REQ[0]=1, regardless of LAST. No preemption of an active grant; the hold limit still applies to requester 0. Requesters 1-3 rotate round-robin among themselves.
- Undefined: pure 4-way round-robin as above.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=0, ST_GRANT=1), REQ_W=4, SEL_W=2, and a default-MAX_HOLD constant.
- One natural sub-module, rr_pick4: combinational. Inputs: 4-bit request vector, 2-bit LAST. Outputs: valid, 2-bit index, one-hot. It is instantiated once in the arbiter; the ARB_PRIO0_EN override is applied around it.

Test Plan:
1. Reset then REQ=0101 held, DONE[0] pulsed after 3 grant cycles -> GNT=0001/S=00 one cycle after REQ. After DONE, next edge GNT=0100/S=10 with no idle cycle.
2. REQ=1111 held, each owner pulses DONE after 2 cycles -> grant order 0,1,2,3,0. S sequence 00,01,10,11,00. BUSY stays 1.
3. REQ=0010 held, no DONE, MAX_HOLD=8 -> TIMEOUT pulses every 8 cycles. GNT stays 0010, HC restarts.
4. REQ=0011 held, no DONE -> requester 1 granted after 8 cycles of requester 0 with TIMEOUT=1. Requester 0 regains after another 8.
5. Grant active on requester 2, RST pulsed one cycle -> next edge GNT=0000, S=00, BUSY=0. With REQ=0100 still high, the first post-reset grant goes to 2 one cycle after RST drops.
6. ARB_PRIO0_EN defined, LAST=0, REQ=1011 at an arbitration point -> GNT=0001. Without the macro -> GNT=0010.
